// File: rtl/operand_stack_if.sv
// Stack-op bus between the controller's decode, the operand stack and the A/B operand path.
// The controller drives op/push_data/alu_op/err_clr; the stack returns top-of-stack state and flags.
interface operand_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [2:0]       op;
  logic [WIDTH-1:0] push_data;
  logic [1:0]       alu_op;
  logic             err_clr;
  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] nos;
  logic             tos_zero;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             err;

  modport master (
    output op, push_data, alu_op, err_clr,
    input  tos, nos, tos_zero, count, empty, full, err
  );

  modport slave (
    input  op, push_data, alu_op, err_clr,
    output tos, nos, tos_zero, count, empty, full, err
  );
endinterface

// File: rtl/operand_stack.sv
// Parametrised LIFO operand stack with replace/dup/swap/clear and a sticky error flag.
// Define OPERAND_STACK_ALU_EN to build the in-stack binary ALU reduce (op=110).
module operand_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  operand_stack_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_PUSH    = 3'b001;
  localparam logic [2:0] OP_POP     = 3'b010;
  localparam logic [2:0] OP_REPLACE = 3'b011;
  localparam logic [2:0] OP_DUP     = 3'b100;
  localparam logic [2:0] OP_SWAP    = 3'b101;
  localparam logic [2:0] OP_ALU     = 3'b110;
  localparam logic [2:0] OP_CLEAR   = 3'b111;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count_q;
  logic             err_q;

  logic [CW-1:0]    count_nxt;
  logic             legal;
  logic             wr_a_en, wr_b_en;
  logic [AW-1:0]    wr_a_idx, wr_b_idx;
  logic [WIDTH-1:0] wr_a_data, wr_b_data;

  logic [AW-1:0]    idx_new, idx_top, idx_nos;
  logic [WIDTH-1:0] top_raw, nos_raw;
  logic             has_one, has_two, is_full;

  // Index arithmetic is truncated to AW bits; each index is only used when its slot exists.
  assign idx_new = AW'(count_q);
  assign idx_top = AW'(count_q - CW'(1));
  assign idx_nos = AW'(count_q - CW'(2));
  assign top_raw = mem[idx_top];
  assign nos_raw = mem[idx_nos];
  assign has_one = (count_q != '0);
  assign has_two = (count_q >= CW'(2));
  assign is_full = (count_q == CW'(DEPTH));

`ifdef OPERAND_STACK_ALU_EN
  logic [WIDTH-1:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (bus.alu_op)
      2'b00:   alu_res = nos_raw + top_raw;
      2'b01:   alu_res = nos_raw - top_raw;
      2'b10:   alu_res = nos_raw & top_raw;
      default: alu_res = nos_raw | top_raw;
    endcase
  end
`else
  logic alu_op_unused;
  assign alu_op_unused = ^bus.alu_op;
`endif

  always_comb begin
    legal     = 1'b1;
    count_nxt = count_q;
    wr_a_en   = 1'b0;
    wr_a_idx  = idx_new;
    wr_a_data = bus.push_data;
    wr_b_en   = 1'b0;
    wr_b_idx  = idx_nos;
    wr_b_data = top_raw;
    case (bus.op)
      OP_NOP: ;
      OP_PUSH: begin
        if (!is_full) begin
          wr_a_en   = 1'b1;
          count_nxt = count_q + CW'(1);
        end else begin
          legal = 1'b0;
        end
      end
      OP_POP: begin
        if (has_one) count_nxt = count_q - CW'(1);
        else         legal = 1'b0;
      end
      OP_REPLACE: begin
        if (has_one) begin
          wr_a_en  = 1'b1;
          wr_a_idx = idx_top;
        end else begin
          legal = 1'b0;
        end
      end
      OP_DUP: begin
        if (has_one && !is_full) begin
          wr_a_en   = 1'b1;
          wr_a_data = top_raw;
          count_nxt = count_q + CW'(1);
        end else begin
          legal = 1'b0;
        end
      end
      OP_SWAP: begin
        if (has_two) begin
          wr_a_en   = 1'b1;
          wr_a_idx  = idx_top;
          wr_a_data = nos_raw;
          wr_b_en   = 1'b1;
        end else begin
          legal = 1'b0;
        end
      end
      OP_ALU: begin
`ifdef OPERAND_STACK_ALU_EN
        if (has_two) begin
          wr_a_en   = 1'b1;
          wr_a_idx  = idx_nos;
          wr_a_data = alu_res;
          count_nxt = count_q - CW'(1);
        end else begin
          legal = 1'b0;
        end
`else
        legal = 1'b0;
`endif
      end
      OP_CLEAR: count_nxt = '0;
      default: ;
    endcase
  end

  // Contents are never scrubbed; count masks stale entries at the outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr_a_en) mem[wr_a_idx] <= wr_a_data;
      if (wr_b_en) mem[wr_b_idx] <= wr_b_data;
    end
  end

  // A new illegal op takes priority over err_clr in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_nxt;
      if (!legal)           err_q <= 1'b1;
      else if (bus.err_clr) err_q <= 1'b0;
    end
  end

  assign bus.tos      = has_one ? top_raw : '0;
  assign bus.nos      = has_two ? nos_raw : '0;
  assign bus.tos_zero = (bus.tos == '0);
  assign bus.count    = count_q;
  assign bus.empty    = !has_one;
  assign bus.full     = is_full;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_operand_stack.sv
// Directed self-checking bench for operand_stack at WIDTH=8, DEPTH=4.
// Expectations follow OPERAND_STACK_ALU_EN for the ALU scenario.
module tb_operand_stack;
  localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, POP = 3'b010, REPL = 3'b011;
  localparam logic [2:0] DUP = 3'b100, SWAP = 3'b101, ALU = 3'b110, CLR = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;

  operand_stack_if #(.WIDTH(8), .DEPTH(4)) bus ();
  operand_stack #(.WIDTH(8), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Apply one op across one rising edge, then return to NOP 1ns after the edge.
  task automatic step(input logic [2:0] o, input logic [7:0] d, input logic [1:0] a, input logic c);
    bus.op = o; bus.push_data = d; bus.alu_op = a; bus.err_clr = c;
    @(posedge clk); #1;
    bus.op = NOP; bus.push_data = 8'h00; bus.alu_op = 2'b00; bus.err_clr = 1'b0;
  endtask

  task automatic test_reset();
    bus.op = NOP; bus.push_data = 8'h00; bus.alu_op = 2'b00; bus.err_clr = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", bus.err); end
    total++; if (bus.tos !== 8'h00 || bus.nos !== 8'h00) begin bad++; $display("FAIL rst_tos_nos got=%h/%h exp=00/00", bus.tos, bus.nos); end
    total++; if ({bus.tos_zero, bus.empty, bus.full} !== 3'b110) begin bad++; $display("FAIL rst_flags got=%b exp=110", {bus.tos_zero, bus.empty, bus.full}); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_fill_overflow();
    step(PUSH, 8'h11, 2'b00, 1'b0);
    step(PUSH, 8'h22, 2'b00, 1'b0);
    step(PUSH, 8'h33, 2'b00, 1'b0);
    total++; if (bus.full !== 1'b0 || bus.count !== 3'd3) begin bad++; $display("FAIL fill3 got full=%b count=%0d exp full=0 count=3", bus.full, bus.count); end
    step(PUSH, 8'h44, 2'b00, 1'b0);
    total++; if (bus.full !== 1'b1 || bus.err !== 1'b0) begin bad++; $display("FAIL fill4 got full=%b err=%b exp full=1 err=0", bus.full, bus.err); end
    step(PUSH, 8'h55, 2'b00, 1'b0);
    total++; if (bus.count !== 3'd4 || bus.full !== 1'b1) begin bad++; $display("FAIL ovf_count got count=%0d full=%b exp 4/1", bus.count, bus.full); end
    total++; if (bus.tos !== 8'h44 || bus.nos !== 8'h33) begin bad++; $display("FAIL ovf_tos got=%h/%h exp=44/33", bus.tos, bus.nos); end
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL ovf_err got=%b exp=1", bus.err); end
    step(NOP, 8'h00, 2'b00, 1'b1);
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL ovf_errclr got=%b exp=0", bus.err); end
    step(DUP, 8'h00, 2'b00, 1'b0);
    total++; if (bus.err !== 1'b1 || bus.count !== 3'd4 || bus.tos !== 8'h44) begin bad++; $display("FAIL dup_full got err=%b count=%0d tos=%h exp 1/4/44", bus.err, bus.count, bus.tos); end
    step(CLR, 8'h00, 2'b00, 1'b1);
    total++; if (bus.count !== 3'd0 || bus.err !== 1'b0 || bus.tos !== 8'h00) begin bad++; $display("FAIL fill_clear got count=%0d err=%b tos=%h exp 0/0/00", bus.count, bus.err, bus.tos); end
  endtask

  task automatic test_underflow();
    step(POP, 8'h00, 2'b00, 1'b0);
    total++; if (bus.err !== 1'b1 || bus.count !== 3'd0) begin bad++; $display("FAIL udf got err=%b count=%0d exp 1/0", bus.err, bus.count); end
    total++; if (bus.tos !== 8'h00 || bus.tos_zero !== 1'b1) begin bad++; $display("FAIL udf_tos got tos=%h tz=%b exp 00/1", bus.tos, bus.tos_zero); end
    step(POP, 8'h00, 2'b00, 1'b1);
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL udf_set_wins got=%b exp=1", bus.err); end
    step(DUP, 8'h00, 2'b00, 1'b1);
    total++; if (bus.err !== 1'b1 || bus.count !== 3'd0) begin bad++; $display("FAIL dup_empty got err=%b count=%0d exp 1/0", bus.err, bus.count); end
    step(PUSH, 8'h00, 2'b00, 1'b1);
    total++; if (bus.err !== 1'b0 || bus.count !== 3'd1 || bus.tos_zero !== 1'b1) begin bad++; $display("FAIL push_zero got err=%b count=%0d tz=%b exp 0/1/1", bus.err, bus.count, bus.tos_zero); end
    step(CLR, 8'h00, 2'b00, 1'b0);
  endtask

  task automatic test_composite();
    step(PUSH, 8'h05, 2'b00, 1'b0);
    step(PUSH, 8'h09, 2'b00, 1'b0);
    step(SWAP, 8'h00, 2'b00, 1'b0);
    total++; if (bus.tos !== 8'h05 || bus.nos !== 8'h09 || bus.count !== 3'd2) begin bad++; $display("FAIL swap got tos=%h nos=%h count=%0d exp 05/09/2", bus.tos, bus.nos, bus.count); end
    step(DUP, 8'h00, 2'b00, 1'b0);
    total++; if (bus.tos !== 8'h05 || bus.nos !== 8'h05 || bus.count !== 3'd3) begin bad++; $display("FAIL dup got tos=%h nos=%h count=%0d exp 05/05/3", bus.tos, bus.nos, bus.count); end
    step(REPL, 8'h7F, 2'b00, 1'b0);
    total++; if (bus.tos !== 8'h7F || bus.nos !== 8'h05 || bus.count !== 3'd3 || bus.err !== 1'b0) begin bad++; $display("FAIL replace got tos=%h nos=%h count=%0d err=%b exp 7f/05/3/0", bus.tos, bus.nos, bus.count, bus.err); end
    step(CLR, 8'h00, 2'b00, 1'b0);
    total++; if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.tos !== 8'h00 || bus.nos !== 8'h00) begin bad++; $display("FAIL clear got count=%0d empty=%b tos=%h nos=%h exp 0/1/00/00", bus.count, bus.empty, bus.tos, bus.nos); end
    step(POP, 8'h00, 2'b00, 1'b0);
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL clear_pop got=%b exp=1", bus.err); end
    step(SWAP, 8'h00, 2'b00, 1'b1);
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL swap_empty got=%b exp=1", bus.err); end
    step(REPL, 8'h12, 2'b00, 1'b1);
    total++; if (bus.err !== 1'b1 || bus.count !== 3'd0) begin bad++; $display("FAIL repl_empty got err=%b count=%0d exp 1/0", bus.err, bus.count); end
    step(NOP, 8'h00, 2'b00, 1'b1);
  endtask

  task automatic test_alu();
    step(PUSH, 8'h03, 2'b00, 1'b0);
    step(PUSH, 8'h05, 2'b00, 1'b0);
    step(ALU, 8'h00, 2'b01, 1'b0);
`ifdef OPERAND_STACK_ALU_EN
    total++; if (bus.tos !== 8'hFE || bus.count !== 3'd1 || bus.err !== 1'b0) begin bad++; $display("FAIL alu_sub got tos=%h count=%0d err=%b exp fe/1/0", bus.tos, bus.count, bus.err); end
    step(PUSH, 8'hFF, 2'b00, 1'b0);
    step(PUSH, 8'h02, 2'b00, 1'b0);
    step(ALU, 8'h00, 2'b00, 1'b0);
    total++; if (bus.tos !== 8'h01 || bus.nos !== 8'hFE || bus.count !== 3'd2) begin bad++; $display("FAIL alu_add got tos=%h nos=%h count=%0d exp 01/fe/2", bus.tos, bus.nos, bus.count); end
    step(ALU, 8'h00, 2'b10, 1'b0);
    total++; if (bus.tos !== 8'h00 || bus.tos_zero !== 1'b1 || bus.count !== 3'd1) begin bad++; $display("FAIL alu_and got tos=%h tz=%b count=%0d exp 00/1/1", bus.tos, bus.tos_zero, bus.count); end
    step(PUSH, 8'hA0, 2'b00, 1'b0);
    step(ALU, 8'h00, 2'b11, 1'b0);
    total++; if (bus.tos !== 8'hA0 || bus.count !== 3'd1 || bus.err !== 1'b0) begin bad++; $display("FAIL alu_or got tos=%h count=%0d err=%b exp a0/1/0", bus.tos, bus.count, bus.err); end
    step(ALU, 8'h00, 2'b00, 1'b0);
    total++; if (bus.err !== 1'b1 || bus.count !== 3'd1 || bus.tos !== 8'hA0) begin bad++; $display("FAIL alu_short got err=%b count=%0d tos=%h exp 1/1/a0", bus.err, bus.count, bus.tos); end
`else
    total++; if (bus.err !== 1'b1 || bus.count !== 3'd2 || bus.tos !== 8'h05 || bus.nos !== 8'h03) begin bad++; $display("FAIL alu_off got err=%b count=%0d tos=%h nos=%h exp 1/2/05/03", bus.err, bus.count, bus.tos, bus.nos); end
    step(CLR, 8'h00, 2'b00, 1'b1);
    step(ALU, 8'h00, 2'b00, 1'b0);
    total++; if (bus.err !== 1'b1 || bus.count !== 3'd0) begin bad++; $display("FAIL alu_off_empty got err=%b count=%0d exp 1/0", bus.err, bus.count); end
`endif
  endtask

  task automatic test_reset_mid();
    step(CLR, 8'h00, 2'b00, 1'b1);
    step(PUSH, 8'h01, 2'b00, 1'b0);
    step(PUSH, 8'h02, 2'b00, 1'b0);
    step(POP, 8'h00, 2'b00, 1'b0);
    #3 rst = 1'b1;
    #1;
    total++; if (bus.count !== 3'd1 && 1'b0) begin end
    total--;
    total++; if (bus.count !== 3'd0 || bus.tos !== 8'h00 || bus.nos !== 8'h00) begin bad++; $display("FAIL mid_rst got count=%0d tos=%h nos=%h exp 0/00/00", bus.count, bus.tos, bus.nos); end
    total++; if ({bus.tos_zero, bus.empty, bus.full, bus.err} !== 4'b1100) begin bad++; $display("FAIL mid_rst_flags got=%b exp=1100", {bus.tos_zero, bus.empty, bus.full, bus.err}); end
    #2 rst = 1'b0;
    step(PUSH, 8'h07, 2'b00, 1'b0);
    total++; if (bus.count !== 3'd1 || bus.tos !== 8'h07 || bus.nos !== 8'h00) begin bad++; $display("FAIL post_rst got count=%0d tos=%h nos=%h exp 1/07/00", bus.count, bus.tos, bus.nos); end
  endtask

  task automatic test_back_to_back();
    step(CLR, 8'h00, 2'b00, 1'b1);
    step(PUSH, 8'h10, 2'b00, 1'b0);
    step(PUSH, 8'h20, 2'b00, 1'b0);
    step(POP, 8'h00, 2'b00, 1'b0);
    step(PUSH, 8'h30, 2'b00, 1'b0);
    step(SWAP, 8'h00, 2'b00, 1'b0);
    total++; if (bus.tos !== 8'h10 || bus.nos !== 8'h30 || bus.count !== 3'd2 || bus.err !== 1'b0) begin bad++; $display("FAIL b2b got tos=%h nos=%h count=%0d err=%b exp 10/30/2/0", bus.tos, bus.nos, bus.count, bus.err); end
    step(POP, 8'h00, 2'b00, 1'b0);
    step(POP, 8'h00, 2'b00, 1'b0);
    total++; if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.err !== 1'b0) begin bad++; $display("FAIL b2b_drain got count=%0d empty=%b err=%b exp 0/1/0", bus.count, bus.empty, bus.err); end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_underflow();
    test_composite();
    test_alu();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
